sync_word_tx: RTL

Serial frame transmitter that drives the single-bit line consumed by our 12-bit sync-word detector. On a start request it latches a payload byte, shifts out the 12-bit sync word 1110_1101_1011 MSB-first, then the payload MSB-first, then a fixed guard gap at idle level. It is the source end of the sync/payload serial link and pairs with the detector on the receive side.

---
 rtl/sync_word_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/sync_word_tx.sv
// Serial frame transmitter: sync word, then payload (both MSB-first), then an idle-level guard gap.
// Feeds the single-bit line watched by the 12-bit sync-word detector.
module sync_word_tx #(
   parameter int unsigned        SYNC_W     = 12,
   parameter logic [SYNC_W-1:0]  SYNC_WORD  = 12'hEDB,
   parameter int unsigned        PAYLOAD_W  = 8,
   parameter int unsigned        GAP_CYCLES = 2,
   parameter logic               IDLE_LEVEL = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [PAYLOAD_W-1:0] data,
   output logic                 ready,
   output logic                 busy,
   output logic                 out,
   output logic                 done
);

   localparam int unsigned MAX_A = (SYNC_W > PAYLOAD_W) ? SYNC_W : PAYLOAD_W;
   localparam int unsigned MAX_B = (MAX_A > GAP_CYCLES + 1) ? MAX_A : GAP_CYCLES + 1;
   localparam int unsigned CW    = (MAX_B > 1) ? $clog2(MAX_B) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SYNC,
      S_PAYLOAD,
      S_GAP
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [PAYLOAD_W-1:0] sh;

   assign ready = (state == S_IDLE);
   assign busy  = (state != S_IDLE);

   // cnt holds the index of the bit currently on the line (sync/payload) or remaining gap cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         out   <= IDLE_LEVEL;
         done  <= 1'b0;
         cnt   <= '0;
         sh    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               out <= IDLE_LEVEL;
               if (start) begin
                  sh    <= data;
                  cnt   <= CW'(SYNC_W - 1);
                  out   <= SYNC_WORD[SYNC_W-1];
                  state <= S_SYNC;
               end
            end
            S_SYNC: begin
               if (cnt == '0) begin
                  out   <= sh[PAYLOAD_W-1];
                  sh    <= sh << 1;
                  cnt   <= CW'(PAYLOAD_W - 1);
                  state <= S_PAYLOAD;
               end else begin
                  out <= SYNC_WORD[cnt - CW'(1)];
                  cnt <= cnt - CW'(1);
               end
            end
            S_PAYLOAD: begin
               if (cnt == '0) begin
                  out  <= IDLE_LEVEL;
                  done <= 1'b1;
                  if (GAP_CYCLES == 0) begin
                     state <= S_IDLE;
                  end else begin
                     cnt   <= CW'(GAP_CYCLES - 1);
                     state <= S_GAP;
                  end
               end else begin
                  out <= sh[PAYLOAD_W-1];
                  sh  <= sh << 1;
                  cnt <= cnt - CW'(1);
               end
            end
            S_GAP: begin
               out <= IDLE_LEVEL;
               if (cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               out   <= IDLE_LEVEL;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
